// File: rtl/vdma_lsram_fifo_ctrl_if.sv
// Bundle of the write stream, burst handshake, read stream, LSRAM port and
// status lines of the LSRAM FIFO controller.
interface vdma_lsram_fifo_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 7
);
  logic              wdata_valid;
  logic [DWIDTH-1:0] wdata;
  logic              wready;
  logic              burst_req;
  logic              burst_ack;
  logic              rdata_valid;
  logic [DWIDTH-1:0] rdata;
  logic              rlast;
  logic              rdata_ready;
  logic              ram_w_en;
  logic [AWIDTH-1:0] ram_w_addr;
  logic [DWIDTH-1:0] ram_w_data;
  logic              ram_r_en;
  logic [AWIDTH-1:0] ram_r_addr;
  logic [DWIDTH-1:0] ram_r_data;
  logic [AWIDTH:0]   level;
  logic              full;
  logic              empty;
  logic              overflow;

  modport slave (
    input  wdata_valid, wdata, burst_ack, rdata_ready, ram_r_data,
    output wready, burst_req, rdata_valid, rdata, rlast,
           ram_w_en, ram_w_addr, ram_w_data, ram_r_en, ram_r_addr,
           level, full, empty, overflow
  );

  modport master (
    output wdata_valid, wdata, burst_ack, rdata_ready, ram_r_data,
    input  wready, burst_req, rdata_valid, rdata, rlast,
           ram_w_en, ram_w_addr, ram_w_data, ram_r_en, ram_r_addr,
           level, full, empty, overflow
  );
endinterface

// File: rtl/vdma_lsram_fifo_ctrl.sv
// Runs a simple dual-port LSRAM as a circular FIFO: pixel beats in, fixed-length
// bursts out, with a 2-entry skid absorbing the RAM's registered read latency.
module vdma_lsram_fifo_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 7,
  parameter int BURST_LEN = 16
) (
  input logic                  clk,
  input logic                  resetn,
  input logic                  flush,
  vdma_lsram_fifo_ctrl_if.slave bus
);

  localparam int              DEPTH   = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] BURST_W = (AWIDTH + 1)'(BURST_LEN);
  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH + 1)'(1);
  localparam logic [AWIDTH:0] CNT_ZERO = (AWIDTH + 1)'(0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [AWIDTH:0]   level_r;
  logic [AWIDTH:0]   issue_cnt;
  logic [AWIDTH:0]   beat_cnt;
  logic [1:0]        state;
  logic              overflow_r;
  logic              inflight;
  logic [1:0]        skid_cnt;
  logic [DWIDTH-1:0] skid0;
  logic [DWIDTH-1:0] skid1;

  logic              full_s;
  logic              rvalid_s;
  logic              w_en;
  logic              r_en;
  logic              pop;
  logic [2:0]        occ;

  assign full_s   = (level_r == DEPTH_W);
  assign rvalid_s = (skid_cnt != 2'd0);

  assign bus.wready      = ~full_s;
  assign bus.full        = full_s;
  assign bus.empty       = (level_r == CNT_ZERO);
  assign bus.level       = level_r;
  assign bus.overflow    = overflow_r;
  assign bus.burst_req   = (state == ST_REQ);
  assign bus.rdata_valid = rvalid_s;
  assign bus.rdata       = skid0;
  assign bus.rlast       = rvalid_s & (beat_cnt == CNT_ONE);
  assign bus.ram_w_en    = w_en;
  assign bus.ram_w_addr  = wptr;
  assign bus.ram_w_data  = bus.wdata;
  assign bus.ram_r_en    = r_en;
  assign bus.ram_r_addr  = rptr;

  // RAM enables; a read is issued only while the skid can still take its data.
  always_comb begin
    pop  = rvalid_s & bus.rdata_ready;
    occ  = {1'b0, skid_cnt} + {2'b00, inflight};
    w_en = resetn & bus.wdata_valid & ~full_s;
    if (resetn && (state == ST_BURST) && (issue_cnt != CNT_ZERO)) begin
      if (occ < 3'd2) begin
        r_en = 1'b1;
      end else if (pop && (occ == 3'd2)) begin
        r_en = 1'b1;
      end else begin
        r_en = 1'b0;
      end
    end else begin
      r_en = 1'b0;
    end
  end

  // Write pointer, fill level and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wptr       <= {AWIDTH{1'b0}};
      level_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (w_en) begin
        wptr <= wptr + 1'b1;
      end else begin
        wptr <= wptr;
      end
      if (bus.wdata_valid && full_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
      case ({w_en, r_en})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Burst FSM with read-issue and beat counters; rptr advances per issued read.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      state     <= ST_IDLE;
      issue_cnt <= CNT_ZERO;
      beat_cnt  <= CNT_ZERO;
      rptr      <= {AWIDTH{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (level_r >= BURST_W) begin
            state <= ST_REQ;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus.burst_ack) begin
            issue_cnt <= BURST_W;
            beat_cnt  <= BURST_W;
            state     <= ST_BURST;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_BURST: begin
          if (r_en && (issue_cnt == CNT_ONE)) begin
            state <= ST_DRAIN;
          end else begin
            state <= ST_BURST;
          end
        end
        ST_DRAIN: begin
          if (beat_cnt == CNT_ZERO) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_DRAIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (r_en) begin
        rptr      <= rptr + 1'b1;
        issue_cnt <= issue_cnt - 1'b1;
      end
      // Beats only exist while a burst is being read, so pop implies BURST/DRAIN.
      if (pop && (beat_cnt != CNT_ZERO)) begin
        beat_cnt <= beat_cnt - 1'b1;
      end
    end
  end

  // Read-latency tracking and 2-entry skid; entry 0 is always the head.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      inflight <= 1'b0;
      skid_cnt <= 2'd0;
      skid0    <= {DWIDTH{1'b0}};
      skid1    <= {DWIDTH{1'b0}};
    end else begin
      inflight <= r_en;
      case ({inflight, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) begin
            skid0 <= bus.ram_r_data;
          end else begin
            skid1 <= bus.ram_r_data;
          end
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= bus.ram_r_data;
          end else begin
            skid0 <= skid1;
            skid1 <= bus.ram_r_data;
          end
          skid_cnt <= skid_cnt;
        end
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_vdma_lsram_fifo_ctrl.sv
// Randomized bench for the LSRAM FIFO controller: a queue-based FIFO model
// predicts every beat, level and flag; scenario tasks add timing checks.
module tb_vdma_lsram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int BL = 16;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  always #5 clk = ~clk;

  vdma_lsram_fifo_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  vdma_lsram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_w_en) mem[bus.ram_w_addr] <= bus.ram_w_data;
    if (bus.ram_r_en) bus.ram_r_data <= mem[bus.ram_r_addr];
  end

  int vecs = 0;
  int errs = 0;
  int mlev, mbeat, mout, popped, both_cnt;
  bit movf, hold, mvalid;
  logic [AW-1:0] mwptr, mrptr;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] exp_q[$];
  logic s_req, s_rvalid, s_rlast, s_ren, s_wen, s_full, s_wready, s_ovf;
  logic [AW:0] s_level;
  logic [DW-1:0] s_rdata;
  logic [5:0] pat = 6'b101001;

  task automatic clear_model();
    mlev = 0; mbeat = 0; mout = 0; movf = 1'b0; hold = 1'b0;
    mwptr = '0; mrptr = '0;
    exp_q.delete();
  endtask

  // One clock: sample at negedge, check against the FIFO model, advance.
  task automatic cyc();
    logic pop;
    logic [DW-1:0] e;
    @(negedge clk);
    s_level = bus.level; s_req = bus.burst_req; s_rvalid = bus.rdata_valid;
    s_rlast = bus.rlast; s_rdata = bus.rdata; s_ren = bus.ram_r_en;
    s_wen = bus.ram_w_en; s_full = bus.full; s_wready = bus.wready; s_ovf = bus.overflow;
    if (!resetn) begin
      vecs++;
      if ({bus.ram_w_en, bus.ram_r_en} !== 2'b00) begin
        errs++; $display("FAIL ram_en_in_reset got %b%b want 00", bus.ram_w_en, bus.ram_r_en);
      end
    end else if (mvalid) begin
      vecs++;
      if (bus.level !== (AW+1)'(mlev)) begin
        errs++; $display("FAIL level got %0d want %0d", bus.level, mlev);
      end
      vecs++;
      if ({bus.full, bus.empty, bus.wready} !== {mlev == DEPTH, mlev == 0, mlev != DEPTH}) begin
        errs++; $display("FAIL full_empty_wready got %b%b%b want level %0d", bus.full, bus.empty, bus.wready, mlev);
      end
      vecs++;
      if (bus.overflow !== movf) begin
        errs++; $display("FAIL overflow got %b want %b", bus.overflow, movf);
      end
      vecs++;
      if (bus.ram_w_en !== (bus.wdata_valid && mlev != DEPTH)) begin
        errs++; $display("FAIL ram_w_en got %b want %b", bus.ram_w_en, bus.wdata_valid && mlev != DEPTH);
      end
      if (bus.ram_w_en) begin
        vecs++;
        if ({bus.ram_w_addr, bus.ram_w_data} !== {mwptr, bus.wdata}) begin
          errs++; $display("FAIL ram_write got %0d/%h want %0d/%h", bus.ram_w_addr, bus.ram_w_data, mwptr, bus.wdata);
        end
      end
      if (bus.ram_r_en) begin
        vecs++;
        if (bus.ram_r_addr !== mrptr) begin
          errs++; $display("FAIL ram_r_addr got %0d want %0d", bus.ram_r_addr, mrptr);
        end
      end
      vecs++;
      if (bus.rlast !== (bus.rdata_valid && mbeat == BL-1)) begin
        errs++; $display("FAIL rlast got %b want %b (beat %0d)", bus.rlast, bus.rdata_valid && mbeat == BL-1, mbeat);
      end
      if (hold) begin
        vecs++;
        if (!(bus.rdata_valid === 1'b1 && bus.rdata === hold_data)) begin
          errs++; $display("FAIL stall_hold got %b/%h want 1/%h", bus.rdata_valid, bus.rdata, hold_data);
        end
      end
      pop = bus.rdata_valid & bus.rdata_ready;
      if (pop) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL rdata got unexpected %h want no beat", bus.rdata);
        end else begin
          e = exp_q.pop_front();
          if (bus.rdata !== e) begin
            errs++; $display("FAIL rdata got %h want %h", bus.rdata, e);
          end
        end
        popped++;
        mbeat = (mbeat == BL-1) ? 0 : mbeat + 1;
      end
      mout = mout + int'(bus.ram_r_en) - int'(pop);
      vecs++;
      if (mout > 2 || mout < 0) begin
        errs++; $display("FAIL outstanding got %0d want 0..2", mout);
      end
      if (bus.ram_w_en && bus.ram_r_en) both_cnt++;
      if (bus.wdata_valid && mlev == DEPTH) movf = 1'b1;
      if (bus.ram_w_en) begin exp_q.push_back(bus.wdata); mwptr++; end
      if (bus.ram_r_en) mrptr++;
      mlev = mlev + int'(bus.ram_w_en) - int'(bus.ram_r_en);
      hold = bus.rdata_valid & ~bus.rdata_ready;
      hold_data = bus.rdata;
    end
    @(posedge clk); #1;
    if (!resetn || flush) begin
      clear_model();
      if (!resetn) mvalid = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    bus.wdata_valid = 1'b0; bus.wdata = '0; bus.burst_ack = 1'b0; bus.rdata_ready = 1'b1;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs(); resetn = 1'b0; cyc(); resetn = 1'b1;
  endtask

  // Streams n_wr words from base, acks bursts if asked, until n_pop beats are read.
  task automatic run(input int n_wr, input logic [DW-1:0] base, input int rmode,
                     input bit acking, input int n_pop, input int budget, input string tag);
    int sent = 0;
    int start = popped;
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      bus.wdata_valid = (sent < n_wr);
      bus.wdata = base + DW'(sent);
      bus.burst_ack = acking & bus.burst_req;
      case (rmode)
        0: bus.rdata_ready = 1'b1;
        1: bus.rdata_ready = pat[c % 6];
        default: bus.rdata_ready = 1'($urandom_range(0, 1));
      endcase
      cyc();
      if (s_wen) sent++;
      done = (sent >= n_wr) && (popped - start >= n_pop);
    end
    vecs++;
    if (!done) begin
      errs++; $display("FAIL %s_timeout got %0d words/%0d beats want %0d/%0d", tag, sent, popped - start, n_wr, n_pop);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [94:0] got;
    logic [94:0] want;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wdata_valid = 1'($urandom); bus.wdata = $urandom; bus.burst_ack = 1'($urandom);
      bus.rdata_ready = 1'($urandom); flush = 1'($urandom);
      cyc();
    end
    idle_inputs();
    bus.rdata_ready = 1'b0;
    @(negedge clk);
    got = {bus.wready, bus.empty, bus.full, bus.overflow, bus.burst_req, bus.rdata_valid,
           bus.rlast, bus.ram_w_en, bus.ram_r_en, bus.level, bus.rdata,
           bus.ram_w_addr, bus.ram_r_addr, bus.ram_w_data};
    want = {9'b110000000, 86'd0};
    vecs++;
    if (got !== want) begin
      errs++; $display("FAIL reset_state got %h want %h", got, want);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    idle_inputs();
  endtask

  task automatic test_single_burst();
    bit ev;
    do_reset();
    for (int i = 0; i < BL; i++) begin
      bus.wdata_valid = 1'b1; bus.wdata = DW'(i); cyc();
    end
    idle_inputs();
    cyc();
    vecs++;
    if ({s_level, s_req} !== {8'd16, 1'b0}) begin
      errs++; $display("FAIL req_pre got level %0d req %b want 16 0", s_level, s_req);
    end
    bus.burst_ack = 1'b1;
    cyc();
    vecs++;
    if (s_req !== 1'b1) begin
      errs++; $display("FAIL req_raise got %b want 1", s_req);
    end
    bus.burst_ack = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      cyc();
      ev = (j >= 3 && j <= 18);
      vecs++;
      if ({s_rvalid, s_rlast} !== {ev, j == 18} || (ev && s_rdata !== DW'(j - 3)) || (j == 1 && s_ren !== 1'b1)) begin
        errs++; $display("FAIL burst_timing cyc N+%0d got v%b l%b d%h r%b want v%b l%b d%h", j, s_rvalid, s_rlast, s_rdata, s_ren, ev, j == 18, j - 3);
      end
    end
    cyc(); cyc();
    vecs++;
    if ({s_level, s_req, s_rvalid} !== 10'd0) begin
      errs++; $display("FAIL burst_end got level %0d req %b v %b want 0 0 0", s_level, s_req, s_rvalid);
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    run(DEPTH, 32'h1000_0000, 0, 1'b0, 0, 300, "fill");
    bus.wdata_valid = 1'b1; bus.wdata = 32'h0000_DEAD;
    cyc();
    vecs++;
    if ({s_full, s_wready, s_wen} !== 3'b100) begin
      errs++; $display("FAIL full_flags got full %b wready %b wen %b want 1 0 0", s_full, s_wready, s_wen);
    end
    idle_inputs();
    cyc();
    vecs++;
    if ({s_ovf, s_level} !== {1'b1, 8'd128}) begin
      errs++; $display("FAIL overflow_set got ovf %b level %0d want 1 128", s_ovf, s_level);
    end
    run(0, '0, 2, 1'b1, DEPTH, 3000, "drain_full");
    cyc(); cyc();
    vecs++;
    if ({s_ovf, s_level} !== {1'b1, 8'd0} || exp_q.size() != 0) begin
      errs++; $display("FAIL overflow_sticky got ovf %b level %0d left %0d want 1 0 0", s_ovf, s_level, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    run(BL, $urandom, 0, 1'b0, 0, 100, "bp_fill");
    run(0, '0, 1, 1'b1, BL, 300, "bp_pattern");
    run(2 * BL, $urandom, 2, 1'b1, 2 * BL, 600, "bp_random");
    cyc();
    vecs++;
    if (exp_q.size() != 0 || s_level !== 8'd0) begin
      errs++; $display("FAIL bp_complete got left %0d level %0d want 0 0", exp_q.size(), s_level);
    end
  endtask

  // Both pointers end at 112 first (the nearest burst multiple below 120),
  // so the next two bursts cross the 127 -> 0 wrap.
  task automatic test_wrap_concurrent();
    do_reset();
    run(112, $urandom, 0, 1'b1, 112, 1000, "wrap_pre");
    both_cnt = 0;
    run(32, '0, 0, 1'b1, 32, 300, "wrap_stream");
    cyc();
    vecs++;
    if (both_cnt == 0 || exp_q.size() != 0 || s_level !== 8'd0 || mrptr !== 7'd16) begin
      errs++; $display("FAIL wrap got both %0d left %0d level %0d rptr %0d want >0 0 0 16", both_cnt, exp_q.size(), s_level, mrptr);
    end
  endtask

  task automatic test_abort(input bit use_reset);
    int start;
    bit ok;
    do_reset();
    run(DEPTH, 32'h2000_0000, 0, 1'b0, 0, 300, "abort_fill");
    bus.wdata_valid = 1'b1; bus.wdata = 32'h0000_DEAD; cyc();
    idle_inputs();
    start = popped;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      bus.burst_ack = bus.burst_req; cyc();
      ok = (popped - start == 5);
    end
    vecs++;
    if (!ok) begin
      errs++; $display("FAIL abort_reach_beat5 got %0d beats want 5", popped - start);
    end
    bus.burst_ack = 1'b0;
    if (use_reset) resetn = 1'b0; else flush = 1'b1;
    cyc();
    resetn = 1'b1; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vecs++;
      if ({s_rvalid, s_rlast, s_ovf, s_req, s_ren, s_level} !== 13'd0) begin
        errs++; $display("FAIL abort_%0d got v%b l%b o%b q%b r%b level %0d want all 0", use_reset, s_rvalid, s_rlast, s_ovf, s_req, s_ren, s_level);
      end
    end
    run(BL, $urandom, 2, 1'b1, BL, 300, "abort_recover");
  endtask

  initial begin
    resetn = 1'b0;
    popped = 0; both_cnt = 0; mvalid = 1'b0;
    clear_model();
    idle_inputs();
    test_reset();
    test_single_burst();
    test_full_overflow();
    test_backpressure();
    test_wrap_concurrent();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
